// File: rtl/modport_multiplier.sv
// Sequential unsigned N x N multiplier: shift-add product, then double-dabble to packed BCD.
// Latency: finish rises 3N edges after the edge that samples start. Back-to-back period is 3N+2 cycles.
// Backpressure: start is sampled only in IDLE. Start and operand changes during MULT/CONV/DONE are ignored.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   request, sampled in IDLE
//   a_in    multiplicand (N bits, unsigned)
//   b_in    multiplier   (N bits, unsigned)
//   out     registered 2N-bit product
//   bcd     registered packed BCD of out, digit 0 in bits [3:0]
//   finish  one-cycle done pulse
module modport_multiplier #(
    parameter int N = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [N-1:0]                   a_in,
    input  logic [N-1:0]                   b_in,
    output logic [2*N-1:0]                 out,
    output logic [4*((2*N)/3+1)-1:0]       bcd,
    output logic                           finish
);

    localparam int D     = (2*N)/3 + 1;
    localparam int BCD_W = 4*D;
    // The counter must reach 2N-1 during CONV.
    localparam int CW    = $clog2(2*N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [2*N-1:0]      r_a;        // multiplicand, shifted left each MULT edge
    logic [N-1:0]        r_b;        // multiplier, shifted right each MULT edge
    logic [2*N-1:0]      r_acc;      // product accumulator; holds the product through CONV
    logic [2*N-1:0]      r_bin;      // binary half of the double-dabble shift register
    logic [BCD_W-1:0]    r_scr;      // BCD scratch half of the double-dabble shift register
    logic [CW-1:0]       r_cnt;

    logic [2*N-1:0]      w_acc_add;
    logic [BCD_W-1:0]    w_scr_adj;
    logic [BCD_W-1:0]    w_scr_shift;
    logic                w_mult_last;
    logic                w_conv_last;

    // Add the shifted multiplicand when the current multiplier LSB is set.
    assign w_acc_add   = r_acc + (r_b[0] ? r_a : '0);
    assign w_mult_last = (r_cnt == CW'(N-1));
    assign w_conv_last = (r_cnt == CW'(2*N-1));

    // Add-3 on every digit >= 5 before the shift, so the digit stays valid
    // decimal after it doubles. Both steps happen within the same edge.
    always_comb begin
        w_scr_adj = r_scr;
        for (int i = 0; i < D; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) begin
                w_scr_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_scr_shift = {w_scr_adj[BCD_W-2:0], r_bin[2*N-1]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)       w_state_nxt = MULT;
            MULT:    if (w_mult_last) w_state_nxt = CONV;
            CONV:    if (w_conv_last) w_state_nxt = DONE;
            DONE:                     w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_bin  <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            out    <= '0;
            bcd    <= '0;
            finish <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= {{N{1'b0}}, a_in};
                        r_b   <= b_in;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                MULT: begin
                    r_acc <= w_acc_add;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    if (w_mult_last) begin
                        // Final partial product folded in here; hand it to the converter.
                        r_bin <= w_acc_add;
                        r_scr <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                CONV: begin
                    r_scr <= w_scr_shift;
                    r_bin <= r_bin << 1;
                    if (w_conv_last) begin
                        out    <= r_acc;
                        bcd    <= w_scr_shift;
                        finish <= 1'b1;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modport_multiplier.sv
// Directed bench for modport_multiplier (N=8).
// Latency: each operation is expected to raise finish 24 edges after the start edge.
// Backpressure: covers start ignored while busy, and start held high across back-to-back operations.
module tb_modport_multiplier;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [15:0] out;
    logic [23:0] bcd;
    logic        finish;

    int checks = 0;
    int errors = 0;

    modport_multiplier #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .out    (out),
        .bcd    (bcd),
        .finish (finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for finish, sampling 1 time unit after each rising edge.
    // Returns the number of edges waited, or 'limit' on timeout.
    task automatic wait_finish(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (finish === 1'b1) return;
        end
        edges = limit;
    endtask

    // Counts finish pulses seen over a number of cycles.
    task automatic count_finish(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) pulses++;
        end
    endtask

    // One full operation with optional busy-time start pulses carrying junk operands.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_out, input logic [23:0] exp_bcd,
                         input bit disturb);
        int edges;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);                 // edge 0 samples start
        #1;
        start = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (finish === 1'b1) break;
            if (disturb && (edges == 4 || edges == 14)) begin
                start = 1'b1;
                a_in  = 8'd200;
                b_in  = 8'd200;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'd24);
        check({tag, "_out"},     32'(out),   32'(exp_out));
        check({tag, "_bcd"},     32'(bcd),   32'(exp_bcd));
        @(posedge clk);
        #1;
        check({tag, "_finish_one_cycle"}, 32'(finish), 32'd0);
    endtask

    initial begin
        int edges;
        int pulses;

        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #2;
        check("reset_out",    32'(out),    32'h0);
        check("reset_bcd",    32'(bcd),    32'h0);
        check("reset_finish", 32'(finish), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Zero and identity.
        do_op("zero",  8'd0,   8'd173, 16'h0000, 24'h000000, 1'b0);
        do_op("ident", 8'd1,   8'd173, 16'h00AD, 24'h000173, 1'b0);
        // Maximum operands and a small mixed case.
        do_op("max",   8'd255, 8'd255, 16'hFE01, 24'h065025, 1'b0);
        do_op("12x10", 8'd12,  8'd10,  16'h0078, 24'h000120, 1'b0);

        // Busy protection: junk start pulses in MULT and CONV are ignored.
        do_op("busy",  8'd7,   8'd9,   16'h003F, 24'h000063, 1'b0 | 1'b1);
        count_finish(40, pulses);
        check("busy_single_finish", 32'(pulses), 32'd0);
        check("busy_out_hold",      32'(out),    32'h003F);
        check("busy_bcd_hold",      32'(bcd),    32'h000063);

        // Async reset mid-cycle clears outputs without waiting for an edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_out", 32'(out), 32'h0);
        check("async_reset_bcd", 32'(bcd), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        a_in  = 8'd100;
        b_in  = 8'd100;
        start = 1'b1;
        @(posedge clk);                 // edge 0
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);      // reach edge 9
        @(posedge clk);                 // edge 10
        #2;
        reset = 1'b1;
        #1;
        check("midop_reset_finish", 32'(finish), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        count_finish(40, pulses);
        check("midop_no_finish", 32'(pulses), 32'd0);
        check("midop_out_zero",  32'(out),    32'h0);
        check("midop_bcd_zero",  32'(bcd),    32'h0);
        do_op("after_reset", 8'd100, 8'd100, 16'h2710, 24'h010000, 1'b0);

        // Back-to-back with start held high; operands changed while busy.
        @(negedge clk);
        a_in  = 8'd3;
        b_in  = 8'd5;
        start = 1'b1;
        @(posedge clk);                 // edge 0 of first op
        #1;
        a_in = 8'd99;
        b_in = 8'd99;
        wait_finish(40, edges);
        check("b2b_first_latency", 32'(edges), 32'd24);
        check("b2b_first_out",     32'(out),   32'h000F);
        check("b2b_first_bcd",     32'(bcd),   32'h000015);
        wait_finish(40, edges);
        check("b2b_period",        32'(edges), 32'd26);
        check("b2b_second_out",    32'(out),   32'h2649);
        check("b2b_second_bcd",    32'(bcd),   32'h009801);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_finish_drop",   32'(finish), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modport_multiplier.md
Name: modport_multiplier

Overview:
- Sequential unsigned N×N multiplier with a start/finish handshake.
- Produces the 2N-bit binary product and its packed-BCD decimal equivalent.
- Uses shift-add multiplication followed by shift-add-3 (double-dabble) binary-to-BCD conversion.
- Sits behind the multiplier bus interface: BFM drives start/a_in/b_in, monitor samples out/bcd/finish.

Parameters:
- N, 8, operand width in bits; N ≥ 2.
- Derived (localparam) D = (2*N)/3 + 1 (integer division), the number of BCD digits. BCD_W = 4*D. For N=8: D=6, BCD_W=24.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse/level; sampled only in IDLE
- a_in  input  N  multiplicand, unsigned
- b_in  input  N  multiplier, unsigned
- out  output  2N  registered binary product a×b
- bcd  output  BCD_W  registered packed BCD of out; digit 0 is bits [3:0], most significant digit at the top
- finish  output  1  one-cycle done pulse

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - out=0, bcd=0, finish=0, and all working registers and counters are cleared.
  - Reset mid-operation aborts the operation; no finish is produced for it.
- States: IDLE, MULT, CONV, DONE.
- IDLE:
  - On a rising edge with start=1, latch a_in/b_in into internal registers, clear the accumulator, set cnt=0, go to MULT.
  - start=0 keeps the block in IDLE.
- MULT (N edges):
  - Each edge: if the multiplier LSB is 1, add the shifted multiplicand into the 2N-bit accumulator.
  - Shift the multiplier right and the multiplicand left; cnt++.
  - After the N-th MULT edge, the product is complete. Load it into a conversion shift register, clear the BCD scratch, go to CONV.
- CONV (2N edges):
  - Each edge: for every BCD scratch digit ≥5 add 3, then shift {scratch, binary} left by 1.
  - Both steps are combinational within one edge.
  - After the 2N-th CONV edge, go to DONE and, on that same edge, register out=product, bcd=scratch, finish=1.
- DONE: lasts exactly one cycle. On the next edge: finish=0, go to IDLE.
- Latency: counting the edge that samples start as edge 0, finish is high between edges 3N and 3N+1. For N=8, that is after edge 24.
- out and bcd change only on the edge that raises finish, and hold until the next finish or reset.
- start while in MULT, CONV or DONE is ignored; operands changing mid-operation have no effect.
- start held high continuously: a new operation begins on the first edge in IDLE, one cycle after finish. Back-to-back period is 3N+2 cycles.
- Arithmetic: unsigned, no overflow possible (2N-bit product). Unused upper BCD digits read 0.
- Testbench-facing timing: outputs are registered, so they are stable for clocking-block sampling at #1 after the edge.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out=0, bcd=0, finish=0 immediately; state IDLE.
- Zero/identity (N=8): a=0,b=173 -> out=0x0000, bcd=0x000000. Then a=1,b=173 -> out=0x00AD, bcd=0x000173. finish pulses exactly one cycle, 24 edges after start.
- Max: a=255,b=255 -> out=0xFE01, bcd=0x065025. a=12,b=10 -> out=0x0078, bcd=0x000120.
- Busy protection: start a=7,b=9, then pulse start with a=200,b=200 during MULT/CONV -> out=63 (0x003F), bcd=0x000063; only one finish pulse.
- Reset mid-op: start a=100,b=100, assert reset at edge 10 -> no finish, out/bcd stay 0. A new start a=100,b=100 -> out=0x2710, bcd=0x010000.
- Back-to-back: start held high with operand pairs (3,5) then (99,99) -> finish pulses 3N+2=26 cycles apart, giving bcd=0x000015 then 0x009801.
